mmio_stream_port: RTL and testbench

- Memory-mapped I/O peripheral on the Processor's external bus (data, address, read, write), directly downstream of the core's load/store path.
- Provides a TX FIFO that the processor writes and an external sink drains via valid/ready.
- Provides an RX FIFO that an external source fills via valid/ready and the processor reads.
- Status and control registers are in the same 32-byte window, so firmware can move streaming data with plain LDUR/STUR.

---
 rtl/mmio_stream_pkg.sv | 34 +++
 rtl/mmio_stream_port_sync_fifo.sv | 68 ++++++
 rtl/mmio_stream_port.sv | 136 +++++++++++++
 tb/tb_mmio_stream_port.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_stream_pkg
// Purpose  : Register map, STATUS layout and CONTROL bits of mmio_stream_port.
// Revision : 1.0
// ============================================================================
package mmio_stream_pkg;

    // Register index is address[4:3]; byte offset = index * 8.
    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,
        REG_RXDATA  = 2'd1,
        REG_STATUS  = 2'd2,
        REG_CONTROL = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [41:0] reserved;
        logic        rx_underflow;   // [21]
        logic        tx_overflow;    // [20]
        logic        rx_empty;       // [19]
        logic        rx_full;        // [18]
        logic        tx_empty;       // [17]
        logic        tx_full;        // [16]
        logic [7:0]  rx_count;       // [15:8]
        logic [7:0]  tx_count;       // [7:0]
    } status_t;

    localparam int c_ctl_flush_tx  = 0;
    localparam int c_ctl_flush_rx  = 1;
    localparam int c_ctl_clr_flags = 2;

endpackage
`default_nettype wire

// File: rtl/mmio_stream_port_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with flush; storage is never reset.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                   c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0]   c_ptr_one = 1;
    localparam logic [c_ptr_w:0]     c_cnt_one = 1;
    localparam logic [c_ptr_w:0]     c_cnt_max = DEPTH[c_ptr_w:0];

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_cnt_max);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_stream_port.sv
`default_nettype none
// ============================================================================
// Module   : mmio_stream_port
// Purpose  : MMIO window with TX/RX stream FIFOs, STATUS and CONTROL registers.
// Revision : 1.0
// ============================================================================
module mmio_stream_port
    import mmio_stream_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_1000,
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       address,
    inout  wire  [DATA_W-1:0] data,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               w_sel;
    reg_sel_e           w_reg;
    logic               w_bus_wr;
    logic               w_bus_rd;
    logic               w_tx_wr;
    logic               w_ctl_wr;
    logic               w_rx_rd;
    logic               w_flush_tx;
    logic               w_flush_rx;
    logic               w_clr_flags;
    logic               w_tx_pop;
    logic               w_rx_push;
    logic [DATA_W-1:0]  w_tx_head;
    logic [DATA_W-1:0]  w_rx_head;
    logic [c_cnt_w-1:0] w_tx_count;
    logic [c_cnt_w-1:0] w_rx_count;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_rx_full;
    logic               w_rx_empty;
    status_t            w_status;
    logic [DATA_W-1:0]  w_rdata;
    logic               r_tx_overflow;
    logic               r_rx_underflow;

    assign w_sel       = (address[63:5] == BASE_ADDR[63:5]) && (address[2:0] == 3'b000);
    assign w_reg       = reg_sel_e'(address[4:3]);
    // Read with write held is a write only, so the bus is never contended.
    assign w_bus_wr    = w_sel && write;
    assign w_bus_rd    = w_sel && read && !write;
    assign w_tx_wr     = w_bus_wr && (w_reg == REG_TXDATA);
    assign w_ctl_wr    = w_bus_wr && (w_reg == REG_CONTROL);
    assign w_rx_rd     = w_bus_rd && (w_reg == REG_RXDATA);
    assign w_flush_tx  = w_ctl_wr && data[c_ctl_flush_tx];
    assign w_flush_rx  = w_ctl_wr && data[c_ctl_flush_rx];
    assign w_clr_flags = w_ctl_wr && data[c_ctl_clr_flags];

    assign out_valid   = !w_tx_empty;
    assign out_data    = w_tx_head;
    assign in_ready    = !w_rx_full;
    assign w_tx_pop    = out_valid && out_ready;
    assign w_rx_push   = in_valid && in_ready;

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_tx_wr),
        .push_data (data),
        .pop       (w_tx_pop),
        .flush     (w_flush_tx),
        .head      (w_tx_head),
        .count     (w_tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_rx_push),
        .push_data (in_data),
        .pop       (w_rx_rd),
        .flush     (w_flush_rx),
        .head      (w_rx_head),
        .count     (w_rx_count),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else if (w_clr_flags) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else begin
            if (w_tx_wr && w_tx_full && !w_tx_pop) r_tx_overflow  <= 1'b1;
            if (w_rx_rd && w_rx_empty)             r_rx_underflow <= 1'b1;
        end
    end

    always_comb begin
        w_status              = '0;
        w_status.tx_count     = 8'(w_tx_count);
        w_status.rx_count     = 8'(w_rx_count);
        w_status.tx_full      = w_tx_full;
        w_status.tx_empty     = w_tx_empty;
        w_status.rx_full      = w_rx_full;
        w_status.rx_empty     = w_rx_empty;
        w_status.tx_overflow  = r_tx_overflow;
        w_status.rx_underflow = r_rx_underflow;
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_RXDATA: if (!w_rx_empty) w_rdata = w_rx_head;
            REG_STATUS: w_rdata = DATA_W'(w_status);
            default:    w_rdata = '0;
        endcase
    end

    assign data = (w_bus_rd && reset) ? w_rdata : 'z;

endmodule
`default_nettype wire

// File: tb/tb_mmio_stream_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_stream_port
// Purpose  : Scoreboard bench: queue-based reference model, separate monitor.
// Revision : 1.0
// ============================================================================
module tb_mmio_stream_port;

    localparam logic [63:0] BASE  = 64'h0000_0000_0000_1000;
    localparam int          DEPTH = 16;
    localparam logic [63:0] HIZ   = '1;   // undriven bus reads back as pulled-up ones

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic [63:0] address   = '0;
    logic        read      = 1'b0;
    logic        write     = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] in_data   = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic        drv_en    = 1'b0;
    logic [63:0] drv_data  = '0;
    wire  [63:0] data;

    pullup (data);
    assign data = drv_en ? drv_data : 'z;

    mmio_stream_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DATA_W(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .data      (data),
        .read      (read),
        .write     (write),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_tx[$];
    logic [63:0] m_rx[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [63:0] exp_rd[$];
    logic [63:0] exp_out[$];
    logic [1:0]  exp_flags[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] m_status();
        logic [63:0] s;
        s = 64'(m_tx.size()) | (64'(m_rx.size()) << 8);
        if (m_tx.size() == DEPTH) s = s | (64'd1 << 16);
        if (m_tx.size() == 0)     s = s | (64'd1 << 17);
        if (m_rx.size() == DEPTH) s = s | (64'd1 << 18);
        if (m_rx.size() == 0)     s = s | (64'd1 << 19);
        if (m_ovf)                s = s | (64'd1 << 20);
        if (m_unf)                s = s | (64'd1 << 21);
        return s;
    endfunction

    // One bus cycle of the reference model: expectations use pre-edge state.
    function automatic void model_step(bit wr, bit rd, logic [63:0] addr, logic [63:0] wd,
                                       bit ordy, bit ivld, logic [63:0] idat);
        bit          sel, is_wr, is_rd, tx_pop, rx_push, tx_full, rx_empty;
        int          off;
        logic [63:0] wde;
        sel      = ((addr >> 5) == (BASE >> 5)) && ((addr & 64'h7) == 0);
        off      = int'((addr >> 3) & 64'h3);
        is_wr    = sel && wr;
        is_rd    = sel && rd && !wr;
        wde      = (wr && !rd) ? wd : HIZ;
        tx_full  = (m_tx.size() == DEPTH);
        rx_empty = (m_rx.size() == 0);
        tx_pop   = ordy && (m_tx.size() > 0);
        rx_push  = ivld && (m_rx.size() < DEPTH);
        exp_flags.push_back({m_tx.size() > 0, m_rx.size() < DEPTH});
        if (rd) begin
            if (!is_rd)        exp_rd.push_back(HIZ);
            else if (off == 1) exp_rd.push_back(rx_empty ? 64'd0 : m_rx[0]);
            else if (off == 2) exp_rd.push_back(m_status());
            else               exp_rd.push_back(64'd0);
        end
        if (tx_pop) exp_out.push_back(m_tx.pop_front());
        if (is_wr && off == 0) begin
            if (!tx_full || tx_pop) m_tx.push_back(wde);
            else                    m_ovf = 1'b1;
        end
        if (is_rd && off == 1) begin
            if (!rx_empty) void'(m_rx.pop_front());
            else           m_unf = 1'b1;
        end
        if (rx_push) m_rx.push_back(idat);
        if (is_wr && off == 3) begin
            if (wde[0]) m_tx.delete();
            if (wde[1]) m_rx.delete();
            if (wde[2]) begin m_ovf = 1'b0; m_unf = 1'b0; end
        end
    endfunction

    task automatic cycle(bit wr, bit rd, logic [63:0] addr, logic [63:0] wd,
                         bit ordy, bit ivld, logic [63:0] idat);
        write     = wr;
        read      = rd;
        address   = addr;
        drv_en    = wr && !rd;
        drv_data  = wd;
        out_ready = ordy;
        in_valid  = ivld;
        in_data   = idat;
        model_step(wr, rd, addr, wd, ordy, ivld, idat);
        @(posedge clock);
        #1;
        write = 1'b0; read = 1'b0; drv_en = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    endtask

    task automatic bus_wr(logic [63:0] off, logic [63:0] wd, bit ordy);
        cycle(1'b1, 1'b0, BASE + off, wd, ordy, 1'b0, '0);
    endtask

    task automatic bus_rd(logic [63:0] addr);
        cycle(1'b0, 1'b1, addr, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(bit ordy, bit ivld, logic [63:0] idat);
        cycle(1'b0, 1'b0, BASE, '0, ordy, ivld, idat);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clock) begin
        logic [1:0] f;
        if (exp_flags.size() > 0) begin
            f = exp_flags.pop_front();
            chk("out_valid", {63'b0, out_valid}, {63'b0, f[1]});
            chk("in_ready",  {63'b0, in_ready},  {63'b0, f[0]});
        end
        if (read) begin
            if (exp_rd.size() == 0) chk("unexpected_read", data, HIZ ^ data);
            else                    chk("bus_read", data, exp_rd.pop_front());
        end
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) chk("unexpected_out", out_data, ~out_data);
            else                     chk("out_data", out_data, exp_out.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_in_ready",  {63'b0, in_ready},  64'd1);
        chk("reset_data_hiz",  data, HIZ);
        reset = 1'b1;
        bus_rd(BASE + 64'h10);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) bus_wr(64'h00, 64'hC0 + 64'(i), 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midreset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midreset_in_ready",  {63'b0, in_ready},  64'd1);
        chk("midreset_data_hiz",  data, HIZ);
        m_tx.delete(); m_rx.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        bus_rd(BASE + 64'h10);

        // TX fill past full, then drain in order.
        for (int i = 0; i < 16; i++) bus_wr(64'h00, 64'hA1 + 64'(i), 1'b0);
        bus_wr(64'h00, 64'hFF, 1'b0);
        bus_rd(BASE + 64'h10);
        for (int i = 0; i < 17; i++) idle(1'b1, 1'b0, '0);
        bus_rd(BASE + 64'h10);
        bus_wr(64'h18, 64'h4, 1'b0);

        // RX path and underflow.
        idle(1'b0, 1'b1, 64'h11);
        idle(1'b0, 1'b1, 64'h22);
        for (int i = 0; i < 3; i++) bus_rd(BASE + 64'h08);
        bus_rd(BASE + 64'h10);
        bus_wr(64'h18, 64'h4, 1'b0);
        bus_rd(BASE + 64'h10);

        // Push into a full TX while the sink drains.
        for (int i = 0; i < 16; i++) bus_wr(64'h00, {$urandom, $urandom}, 1'b0);
        bus_wr(64'h00, 64'h55, 1'b1);
        bus_rd(BASE + 64'h10);
        for (int i = 0; i < 17; i++) idle(1'b1, 1'b0, '0);

        // Flush RX against a simultaneous stream push.
        for (int i = 0; i < 5; i++) idle(1'b0, 1'b1, 64'h300 + 64'(i));
        bus_rd(BASE + 64'h10);
        cycle(1'b1, 1'b0, BASE + 64'h18, 64'h2, 1'b0, 1'b1, 64'hDEAD);
        bus_rd(BASE + 64'h10);

        // Decode: unaligned, out of window, read+write together.
        idle(1'b0, 1'b1, 64'h77);
        bus_rd(BASE + 64'h04);
        bus_rd(BASE + 64'h20);
        bus_rd(BASE - 64'h08);
        cycle(1'b1, 1'b0, BASE + 64'h20, 64'h99, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, BASE + 64'h10, '0, 1'b0, 1'b0, '0);
        bus_rd(BASE + 64'h10);
        bus_rd(BASE + 64'h00);
        bus_rd(BASE + 64'h18);
        bus_wr(64'h18, 64'h7, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 19));
            if (r <= 5)
                cycle(1'b1, 1'b0, BASE, {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
                      1'($urandom), {$urandom, $urandom});
            else if (r <= 9)
                cycle(1'b0, 1'b1, BASE + 64'h08, '0, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            else if (r <= 11)
                cycle(1'b0, 1'b1, BASE + 64'h10, '0, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            else if (r == 12)
                cycle(1'b1, 1'b0, BASE + 64'h18, 64'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                      {$urandom, $urandom});
            else if (r == 13)
                cycle(1'b0, 1'b1, BASE + 64'($urandom_range(0, 31)), '0, 1'($urandom), 1'($urandom),
                      {$urandom, $urandom});
            else
                idle(1'($urandom), 1'($urandom), {$urandom, $urandom});
        end
        for (int i = 0; i < 17; i++) idle(1'b1, 1'b0, '0);
        bus_rd(BASE + 64'h10);

        @(negedge clock);
        #1;
        chk("exp_out_left", 64'(exp_out.size()), 64'd0);
        chk("exp_rd_left",  64'(exp_rd.size()),  64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
